sc_matrix_max7219_driver: RTL and testbench

- Downstream display stage of the main game state machine.
- Takes the 8 row patterns (8 bits each) that the state machine presents for the current screen, e.g. the level-number glyph.
- Serialises them to a MAX7219 8x8 LED matrix controller over its 3-wire interface (DIN/CLK/LOAD).
- After reset it runs the MAX7219 initialisation sequence on its own, then rewrites the whole matrix on every load request.

---
 rtl/sc_matrix_max7219_driver_pkg.sv | 43 ++++
 rtl/sc_matrix_max7219_driver_shift.sv | 116 +++++++++++
 rtl/sc_matrix_max7219_driver.sv | 130 +++++++++++++
 tb/tb_sc_matrix_max7219_driver.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_matrix_max7219_driver_pkg.sv
// Shared definitions for the MAX7219 matrix driver: register addresses,
// FSM/phase encodings and the fixed power-up word list.
package sc_matrix_max7219_driver_pkg;

    localparam logic [7:0] ADDR_DIGIT0    = 8'h01;
    localparam logic [7:0] ADDR_DECODE    = 8'h09;
    localparam logic [7:0] ADDR_INTENSITY = 8'h0A;
    localparam logic [7:0] ADDR_SCANLIMIT = 8'h0B;
    localparam logic [7:0] ADDR_SHUTDOWN  = 8'h0C;
    localparam logic [7:0] ADDR_TEST      = 8'h0F;

    localparam logic [3:0] INIT_WORDS  = 4'd5;
    localparam logic [3:0] FRAME_WORDS = 4'd8;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_FRAME
    } main_state_e;

    typedef enum logic [2:0] {
        PH_IDLE,
        PH_SETUP,
        PH_HIGH,
        PH_LOW,
        PH_GAP
    } shift_phase_e;

    function automatic logic [15:0] init_word(input logic [2:0] idx,
                                              input logic [3:0] intensity,
                                              input logic [2:0] scan_limit);
        logic [15:0] w;
        case (idx)
            3'd0:    w = {ADDR_TEST, 8'h00};
            3'd1:    w = {ADDR_DECODE, 8'h00};
            3'd2:    w = {ADDR_INTENSITY, 4'h0, intensity};
            3'd3:    w = {ADDR_SCANLIMIT, 5'h00, scan_limit};
            default: w = {ADDR_SHUTDOWN, 8'h01};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/sc_matrix_max7219_driver_shift.sv
// 16-bit MSB-first serialiser for the MAX7219 3-wire bus. A word is accepted
// on start while ready is high; done marks the last GAP cycle, where a new
// start chains the next word with no idle cycle.
module sc_max7219_shift
    import sc_matrix_max7219_driver_pkg::*;
#(
    parameter int DIV_HALF = 25
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] word_InBus,
    output logic        ready,
    output logic        done,
    output logic        din,
    output logic        sclk,
    output logic        cs_n
);

    localparam int CW = $clog2(DIV_HALF + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV_HALF - 1);

    shift_phase_e   phase_q, phase_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [3:0]     bit_q, bit_d;
    logic [15:0]    sreg_q, sreg_d;
    logic           din_q, din_d;
    logic           sclk_q, sclk_d;
    logic           cs_n_q, cs_n_d;
    logic           last;

    assign last  = (cnt_q == CNT_LAST);
    assign done  = (phase_q == PH_GAP) && last;
    assign ready = (phase_q == PH_IDLE) || done;

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sreg_d  = sreg_q;
        if (phase_q != PH_IDLE) begin
            cnt_d = last ? '0 : cnt_q + 1'b1;
        end
        case (phase_q)
            PH_IDLE: begin
                if (start) begin
                    phase_d = PH_SETUP;
                    sreg_d  = word_InBus;
                    bit_d   = 4'd15;
                end
            end
            PH_SETUP: begin
                if (last) phase_d = PH_HIGH;
            end
            PH_HIGH: begin
                // bit_q is decremented on entry to LOW so LOW already presents the next bit
                if (last) begin
                    if (bit_q == 4'd0) begin
                        phase_d = PH_GAP;
                    end else begin
                        phase_d = PH_LOW;
                        bit_d   = bit_q - 4'd1;
                    end
                end
            end
            PH_LOW: begin
                if (last) phase_d = PH_HIGH;
            end
            PH_GAP: begin
                if (last) begin
                    if (start) begin
                        phase_d = PH_SETUP;
                        sreg_d  = word_InBus;
                        bit_d   = 4'd15;
                    end else begin
                        phase_d = PH_IDLE;
                    end
                end
            end
            default: phase_d = PH_IDLE;
        endcase

        din_d  = 1'b0;
        sclk_d = (phase_d == PH_HIGH);
        cs_n_d = 1'b1;
        if ((phase_d == PH_SETUP) || (phase_d == PH_HIGH) || (phase_d == PH_LOW)) begin
            cs_n_d = 1'b0;
            din_d  = sreg_d[bit_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PH_IDLE;
            cnt_q   <= '0;
            bit_q   <= 4'd0;
            sreg_q  <= 16'h0000;
            din_q   <= 1'b0;
            sclk_q  <= 1'b0;
            cs_n_q  <= 1'b1;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sreg_q  <= sreg_d;
            din_q   <= din_d;
            sclk_q  <= sclk_d;
            cs_n_q  <= cs_n_d;
        end
    end

    assign din  = din_q;
    assign sclk = sclk_q;
    assign cs_n = cs_n_q;

endmodule

// File: rtl/sc_matrix_max7219_driver.sv
// MAX7219 8x8 matrix driver: runs the power-up register sequence, then writes
// all eight digit rows from a shadow copy on each load request.
module sc_matrix_max7219_driver
    import sc_matrix_max7219_driver_pkg::*;
#(
    parameter int         DIV_HALF   = 25,
    parameter logic [3:0] INTENSITY  = 4'h8,
    parameter logic [2:0] SCAN_LIMIT = 3'h7
) (
    input  logic        SC_MATRIXDRIVER_CLOCK_50,
    input  logic        SC_MATRIXDRIVER_RESET_InLow,
    input  logic [63:0] SC_MATRIXDRIVER_rows_InBus,
    input  logic        SC_MATRIXDRIVER_load_InHigh,
    output logic        SC_MATRIXDRIVER_busy_OutHigh,
    output logic        SC_MATRIXDRIVER_done_OutHigh,
    output logic        SC_MATRIXDRIVER_din_Out,
    output logic        SC_MATRIXDRIVER_sclk_Out,
    output logic        SC_MATRIXDRIVER_cs_OutLow
);

    main_state_e  state_q, state_d;
    logic [3:0]   idx_q, idx_d;
    logic [63:0]  shadow_q, shadow_d;
    logic [63:0]  pend_buf_q, pend_buf_d;
    logic         pending_q, pending_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic         shift_start;
    logic [15:0]  shift_word;
    logic         shift_ready;
    logic         shift_done;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        shadow_d    = shadow_q;
        pend_buf_d  = pend_buf_q;
        pending_d   = pending_q;
        done_d      = 1'b0;
        shift_start = 1'b0;
        shift_word  = 16'h0000;

        case (state_q)
            ST_INIT: begin
                if (SC_MATRIXDRIVER_load_InHigh) begin
                    pending_d  = 1'b1;
                    pend_buf_d = SC_MATRIXDRIVER_rows_InBus;
                end
                if (shift_ready && (idx_q < INIT_WORDS)) begin
                    shift_start = 1'b1;
                    shift_word  = init_word(idx_q[2:0], INTENSITY, SCAN_LIMIT);
                    idx_d       = idx_q + 4'd1;
                end else if (shift_done) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                // a fresh load beats an older pending buffer
                if (SC_MATRIXDRIVER_load_InHigh) begin
                    shadow_d  = SC_MATRIXDRIVER_rows_InBus;
                    pending_d = 1'b0;
                    idx_d     = 4'd0;
                    state_d   = ST_FRAME;
                end else if (pending_q) begin
                    shadow_d  = pend_buf_q;
                    pending_d = 1'b0;
                    idx_d     = 4'd0;
                    state_d   = ST_FRAME;
                end
            end
            ST_FRAME: begin
                if (SC_MATRIXDRIVER_load_InHigh) begin
                    pending_d  = 1'b1;
                    pend_buf_d = SC_MATRIXDRIVER_rows_InBus;
                end
                if (shift_ready && (idx_q < FRAME_WORDS)) begin
                    shift_start = 1'b1;
                    shift_word  = {ADDR_DIGIT0 + {5'b00000, idx_q[2:0]},
                                   shadow_q[{idx_q[2:0], 3'b000} +: 8]};
                    idx_d       = idx_q + 4'd1;
                end else if (shift_done) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_INIT;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge SC_MATRIXDRIVER_CLOCK_50 or negedge SC_MATRIXDRIVER_RESET_InLow) begin
        if (!SC_MATRIXDRIVER_RESET_InLow) begin
            state_q    <= ST_INIT;
            idx_q      <= 4'd0;
            shadow_q   <= 64'h0;
            pend_buf_q <= 64'h0;
            pending_q  <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            shadow_q   <= shadow_d;
            pend_buf_q <= pend_buf_d;
            pending_q  <= pending_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    sc_max7219_shift #(
        .DIV_HALF(DIV_HALF)
    ) u_shift (
        .clk       (SC_MATRIXDRIVER_CLOCK_50),
        .rst_n     (SC_MATRIXDRIVER_RESET_InLow),
        .start     (shift_start),
        .word_InBus(shift_word),
        .ready     (shift_ready),
        .done      (shift_done),
        .din       (SC_MATRIXDRIVER_din_Out),
        .sclk      (SC_MATRIXDRIVER_sclk_Out),
        .cs_n      (SC_MATRIXDRIVER_cs_OutLow)
    );

    assign SC_MATRIXDRIVER_busy_OutHigh = busy_q;
    assign SC_MATRIXDRIVER_done_OutHigh = done_q;

endmodule

// File: tb/tb_sc_matrix_max7219_driver.sv
// Bench for the MAX7219 matrix driver: decodes the serial bus back into words
// and compares them with a frame-level model of init, loads and pending data.
module tb_sc_matrix_max7219_driver;

    localparam int         D     = 2;
    localparam logic [3:0] INT_V = 4'h8;
    localparam logic [2:0] SCN_V = 3'h7;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        load  = 1'b0;
    logic [63:0] rows  = 64'h0;
    logic        busy, done, din, sclk, cs_n;

    sc_matrix_max7219_driver #(
        .DIV_HALF  (D),
        .INTENSITY (INT_V),
        .SCAN_LIMIT(SCN_V)
    ) dut (
        .SC_MATRIXDRIVER_CLOCK_50   (clk),
        .SC_MATRIXDRIVER_RESET_InLow(rst_n),
        .SC_MATRIXDRIVER_rows_InBus (rows),
        .SC_MATRIXDRIVER_load_InHigh(load),
        .SC_MATRIXDRIVER_busy_OutHigh(busy),
        .SC_MATRIXDRIVER_done_OutHigh(done),
        .SC_MATRIXDRIVER_din_Out    (din),
        .SC_MATRIXDRIVER_sclk_Out   (sclk),
        .SC_MATRIXDRIVER_cs_OutLow  (cs_n)
    );

    // clock / reset
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // reference model: ordered list of words the bus must carry
    logic [15:0] exp_q[$];
    logic [63:0] pend_rows   = 64'h0;
    bit          has_pend    = 1'b0;
    bit          model_idle  = 1'b0;
    bit          job_is_frame = 1'b0;
    int          words_left  = 0;
    int          exp_done    = 0;

    function automatic logic [15:0] frame_word(input logic [63:0] r, input int k);
        return {8'(k), r[8*(k-1) +: 8]};
    endfunction

    task automatic model_start_frame(input logic [63:0] r);
        for (int k = 1; k <= 8; k++) exp_q.push_back(frame_word(r, k));
        words_left   = 8;
        job_is_frame = 1'b1;
        model_idle   = 1'b0;
    endtask

    task automatic model_reset();
        exp_q.delete();
        has_pend = 1'b0;
        exp_q.push_back(16'h0F00);
        exp_q.push_back(16'h0900);
        exp_q.push_back({8'h0A, 4'h0, INT_V});
        exp_q.push_back({8'h0B, 5'h00, SCN_V});
        exp_q.push_back(16'h0C01);
        words_left   = 5;
        job_is_frame = 1'b0;
        model_idle   = 1'b0;
    endtask

    task automatic model_load(input logic [63:0] r);
        if (model_idle) begin
            model_start_frame(r);
        end else begin
            pend_rows = r;
            has_pend  = 1'b1;
        end
    endtask

    task automatic model_word_seen();
        words_left--;
        if (words_left == 0) begin
            if (job_is_frame) exp_done++;
            if (has_pend) begin
                has_pend = 1'b0;
                model_start_frame(pend_rows);
            end else begin
                model_idle = 1'b1;
            end
        end
    endtask

    // bus monitor / scoreboard
    logic        prev_cs = 1'b1, prev_sclk = 1'b0, prev_done = 1'b0;
    int          lo_run = 0, hi_run = 0, mon_bits = 0, setup_cyc = 0, done_cnt = 0;
    logic [15:0] sh = 16'h0;
    logic        hold_din = 1'b0;
    bit          bad_w = 1'b0, bad_s = 1'b0, idle_bad = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_cs = 1'b1; prev_sclk = 1'b0; prev_done = 1'b0;
            mon_bits = 0; lo_run = 0; hi_run = 0;
        end else begin
            if (done) begin
                done_cnt++;
                check_eq("done_one_cycle", prev_done, 1'b0);
            end
            if (prev_cs && !cs_n) begin
                mon_bits = 0; sh = 16'h0; lo_run = 1; hi_run = 0;
                bad_w = 1'b0; bad_s = 1'b0; setup_cyc = cyc;
                if (sclk) bad_w = 1'b1;
            end else if (!prev_cs && cs_n) begin
                if (hi_run != D || sclk) bad_w = 1'b1;
                check_eq("word_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) check_eq("word", sh, exp_q.pop_front());
                check_eq("word_bits", mon_bits, 16);
                check_eq("sclk_widths", bad_w, 1'b0);
                check_eq("din_stable", bad_s, 1'b0);
                check_eq("cs_low_len", cyc - setup_cyc, 32 * D);
                model_word_seen();
            end else if (!cs_n) begin
                if (!prev_sclk && sclk) begin
                    if (lo_run != D) bad_w = 1'b1;
                    lo_run = 0; hi_run = 1;
                    sh = {sh[14:0], din};
                    mon_bits++;
                    hold_din = din;
                end else if (prev_sclk && !sclk) begin
                    if (hi_run != D) bad_w = 1'b1;
                    hi_run = 0; lo_run = 1;
                end else if (sclk) begin
                    hi_run++;
                    if (din !== hold_din) bad_s = 1'b1;
                end else begin
                    lo_run++;
                end
            end else if (sclk || din) begin
                idle_bad = 1'b1;
            end
            prev_cs = cs_n; prev_sclk = sclk; prev_done = done;
        end
    end

    // driver tasks
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return cs_n;
            1:       return busy;
            default: return done;
        endcase
    endfunction

    task automatic wait_sig(input string tag, input int sel, input logic val,
                            input int max, output int t);
        t = -1;
        for (int i = 0; i < max; i++) begin
            if (sig(sel) === val) begin
                t = cyc;
                break;
            end
            tick();
        end
        if (t < 0) check_eq({tag, "_timeout"}, 1'b1, 1'b0);
    endtask

    task automatic wait_done_pulse(input string tag, output int t);
        int tl;
        wait_sig({tag, "_lo"}, 2, 1'b0, 10, tl);
        wait_sig(tag, 2, 1'b1, 3000, t);
    endtask

    task automatic do_load(input logic [63:0] r);
        rows = r;
        load = 1'b1;
        model_load(r);
        tick();
        load = 1'b0;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    int t0, t1, t2, base;

    initial begin
        model_reset();
        repeat (3) tick();
        check_eq("rst_din", din, 1'b0);
        check_eq("rst_sclk", sclk, 1'b0);
        check_eq("rst_cs", cs_n, 1'b1);
        check_eq("rst_busy", busy, 1'b1);
        check_eq("rst_done", done, 1'b0);

        rst_n = 1'b1;
        wait_sig("init_start", 0, 1'b0, 10, t0);
        wait_sig("init_end", 1, 1'b0, 1000, t1);
        check_eq("init_len", t1 - t0, 330);
        check_eq("init_no_done", done_cnt, 0);
        check_eq("init_words_left", exp_q.size(), 0);

        // digit glyph from an idle start
        tick();
        do_load(64'h003C181818381800);
        wait_sig("frame_start", 0, 1'b0, 10, t0);
        wait_done_pulse("frame_done", t1);
        check_eq("frame_len", t1 - t0, 528);
        tick();
        check_eq("busy_after_frame", busy, 1'b0);
        check_eq("frame_done_cnt", done_cnt, exp_done);
        check_eq("frame_words_left", exp_q.size(), 0);

        // random idle loads
        for (int n = 0; n < 3; n++) begin
            do_load(rnd64());
            wait_done_pulse("rnd_done", t1);
            repeat ($urandom_range(1, 20)) tick();
            check_eq("rnd_done_cnt", done_cnt, exp_done);
        end

        // two loads during a frame: newest wins, one follow-up frame
        base = done_cnt;
        do_load(rnd64());
        wait_sig("ab_start", 0, 1'b0, 10, t0);
        repeat ($urandom_range(20, 200)) tick();
        do_load(rnd64());
        repeat ($urandom_range(10, 100)) tick();
        do_load(rnd64());
        wait_done_pulse("ab_done1", t1);
        wait_done_pulse("ab_done2", t2);
        repeat (200) tick();
        check_eq("ab_two_dones", done_cnt - base, 2);
        check_eq("ab_done_model", done_cnt, exp_done);
        check_eq("ab_words_left", exp_q.size(), 0);

        // load coinciding with done
        do_load(rnd64());
        wait_done_pulse("cd_done1", t1);
        do_load(rnd64());
        wait_sig("cd_start2", 0, 1'b0, 10, t2);
        check_eq("cd_no_idle_wait", (t2 - t1) <= 3, 1'b1);
        wait_done_pulse("cd_done2", t1);
        repeat (20) tick();
        check_eq("cd_done_model", done_cnt, exp_done);
        check_eq("cd_words_left", exp_q.size(), 0);

        // reset at bit 7 of a word, then a load during the re-init
        do_load(rnd64());
        wait_sig("rst_frame_start", 0, 1'b0, 10, t0);
        t1 = -1;
        for (int i = 0; i < 2000; i++) begin
            if (mon_bits == 9 && sclk) begin
                t1 = i;
                break;
            end
            tick();
        end
        check_eq("bit7_reached", t1 >= 0, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_cs", cs_n, 1'b1);
        check_eq("midrst_sclk", sclk, 1'b0);
        check_eq("midrst_busy", busy, 1'b1);
        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;
        repeat ($urandom_range(20, 200)) tick();
        check_eq("reinit_busy", busy, 1'b1);
        do_load(rnd64());
        wait_done_pulse("reinit_done", t1);
        repeat (20) tick();
        check_eq("reinit_done_model", done_cnt, exp_done);
        check_eq("reinit_words_left", exp_q.size(), 0);
        check_eq("idle_lines_quiet", idle_bad, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
